// File: rtl/vga_rx_monitor_if.sv
// VGA pin bundle as seen at the connector: sync pulses, blanking and colour.
// The monitor only ever takes the slave view; the display path owns master.
interface vga_rx_monitor_if;
  logic       hsync;
  logic       vsync;
  logic       blank_b;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output hsync, vsync, blank_b, r, g, b);
  modport slave  (input  hsync, vsync, blank_b, r, g, b);
endinterface

// File: rtl/vga_rx_monitor.sv
// Passive VGA receive monitor: checks raster timing against the expected geometry,
// recovers active x/y and captures one pixel per frame for board self-test.
module vga_rx_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SAMPLE_X = 320,
  parameter int SAMPLE_Y = 240
) (
  input  logic        vgaclk,
  input  logic        rst_n,
  vga_rx_monitor_if.slave vga,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pixel_valid,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic        frame_done,
  output logic        timing_err,
  output logic [7:0]  err_count,
  output logic [23:0] sample_rgb,
  output logic        sample_valid
);
  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] SX  = 10'(SAMPLE_X);
  localparam logic [9:0] SY  = 10'(SAMPLE_Y);
  localparam logic [9:0] SAT = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state;

  logic        hs_q, vs_q, bl_q, hs_p, vs_p;
  logic [23:0] rgb_q;
  logic [9:0]  hcnt, lcnt, acnt, vact;
  logic        h_seen, bad;

  function automatic logic [9:0] inc10(input logic [9:0] v);
    return (v == SAT) ? v : v + 10'd1;
  endfunction

  logic       hs_edge, vs_edge, line_bad, frame_bad, hsat, err_now, is_locked;
  logic [9:0] lcnt_l, vact_l, acnt_c, y_c;

  always_comb begin
    hs_edge   = hs_p & ~hs_q;
    vs_edge   = vs_p & ~vs_q;
    is_locked = (state == LOCKED);
    // The first line after reset has no known start, so it is never judged.
    line_bad  = hs_edge && h_seen &&
                ((inc10(hcnt) != HT) || ((acnt != 10'd0) && (acnt != HA)));
    hsat      = (hcnt == SAT) && !hs_edge;
    // A line closing on the vsync edge still belongs to the frame being closed.
    lcnt_l    = hs_edge ? inc10(lcnt) : lcnt;
    vact_l    = (hs_edge && (acnt != 10'd0)) ? inc10(vact) : vact;
    frame_bad = vs_edge && ((lcnt_l != VT) || (vact_l != VA));
    acnt_c    = hs_edge ? 10'd0 : acnt;
    y_c       = vs_edge ? 10'd0 : vact_l;
    err_now   = is_locked && (line_bad || frame_bad || hsat);
  end

  assign locked = is_locked;

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEARCH;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      bl_q         <= 1'b0;
      hs_p         <= 1'b0;
      vs_p         <= 1'b0;
      rgb_q        <= '0;
      hcnt         <= '0;
      lcnt         <= '0;
      acnt         <= '0;
      vact         <= '0;
      h_seen       <= 1'b0;
      bad          <= 1'b0;
      x            <= '0;
      y            <= '0;
      pixel_valid  <= 1'b0;
      line_len     <= '0;
      frame_lines  <= '0;
      frame_done   <= 1'b0;
      timing_err   <= 1'b0;
      err_count    <= '0;
      sample_rgb   <= '0;
      sample_valid <= 1'b0;
    end else begin
      hs_q  <= vga.hsync;
      vs_q  <= vga.vsync;
      bl_q  <= vga.blank_b;
      rgb_q <= {vga.r, vga.g, vga.b};
      hs_p  <= hs_q;
      vs_p  <= vs_q;

      if (hs_edge) begin
        line_len <= inc10(hcnt);
        hcnt     <= '0;
        h_seen   <= 1'b1;
      end else begin
        hcnt <= inc10(hcnt);
      end
      acnt <= bl_q ? inc10(acnt_c) : acnt_c;

      if (vs_edge) begin
        frame_lines <= lcnt_l;
        lcnt        <= '0;
        vact        <= '0;
      end else begin
        lcnt <= lcnt_l;
        vact <= vact_l;
      end

      frame_done  <= vs_edge;
      timing_err  <= err_now;
      x           <= acnt_c;
      y           <= y_c;
      pixel_valid <= bl_q && is_locked;

      if (bl_q && is_locked && (acnt_c == SX) && (y_c == SY)) begin
        sample_rgb   <= rgb_q;
        sample_valid <= 1'b1;
      end
      if (err_now) begin
        sample_valid <= 1'b0;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      // Line counters run freely across the SEARCH->MEASURE hand-off so the
      // line in flight is still measured correctly; only frame verdict resets.
      case (state)
        SEARCH: if (vs_edge) begin
          state <= MEASURE;
          bad   <= 1'b0;
        end
        MEASURE: if (vs_edge) begin
          if (!bad && !line_bad && !frame_bad) state <= LOCKED;
          bad <= 1'b0;
        end else if (line_bad || hsat) begin
          bad <= 1'b1;
        end
        LOCKED: if (err_now) state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a shrunken 12x7 raster (8x4 active)
// so that lock, error and saturation scenarios fit in a short run.
module tb_vga_rx_monitor;
  localparam int HT = 12;
  localparam int VT = 7;
  localparam int HA = 8;
  localparam int VA = 4;
  localparam int SX = 5;
  localparam int SY = 2;
  localparam int VS_SIM = HA + 1;  // vsync falling together with hsync

  logic        vgaclk;
  logic        rst_n;
  logic [9:0]  x, y, line_len, frame_lines;
  logic        pixel_valid, locked, frame_done, timing_err, sample_valid;
  logic [7:0]  err_count;
  logic [23:0] sample_rgb;

  vga_rx_monitor_if vif ();

  vga_rx_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .SAMPLE_X(SX), .SAMPLE_Y(SY)
  ) dut (
    .vgaclk      (vgaclk),
    .rst_n       (rst_n),
    .vga         (vif),
    .x           (x),
    .y           (y),
    .pixel_valid (pixel_valid),
    .locked      (locked),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .frame_done  (frame_done),
    .timing_err  (timing_err),
    .err_count   (err_count),
    .sample_rgb  (sample_rgb),
    .sample_valid(sample_valid)
  );

  initial vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  int ntests = 0;
  int nfail  = 0;
  int te_cnt = 0;
  int te0;

  always @(negedge vgaclk) if (timing_err === 1'b1) te_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One raster frame. hsync falls at p=HA+1; vsync falls at line VA+1, pixel vpos.
  task automatic frame(input int nlines, input int short_ln, input int vpos,
                       input bit chk, input bit exp_err);
    for (int ln = 0; ln < nlines; ln++) begin
      int len;
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        logic bl;
        @(negedge vgaclk);
        if (chk) begin
          if (ln == SY && p == SX + 2) begin
            check("x", 32'(x), SX);
            check("y", 32'(y), SY);
            check("pixel_valid", 32'(pixel_valid), 1);
          end
          if (ln == VA && p == 2) check("pixel_valid_blank", 32'(pixel_valid), 0);
          if (ln == VA + 1 && p == vpos + 2) begin
            check("frame_done", 32'(frame_done), 1);
            check("timing_err_at_vs", 32'(timing_err), 32'(exp_err));
          end
          if (ln == VA + 1 && p == vpos + 3) check("frame_done_pulse", 32'(frame_done), 0);
        end
        bl = (ln < VA) && (p < HA);
        vif.hsync   = !(p == HA + 1 || p == HA + 2);
        vif.vsync   = !((ln == VA + 1 && p >= vpos) || (ln == VA + 2 && p < vpos));
        vif.blank_b = bl;
        vif.r       = bl ? 8'(p)  : 8'h00;
        vif.g       = bl ? 8'(ln) : 8'h00;
        vif.b       = bl ? 8'h5A  : 8'h00;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},            32'(x), 0);
    check({tag, "_y"},            32'(y), 0);
    check({tag, "_pixel_valid"},  32'(pixel_valid), 0);
    check({tag, "_locked"},       32'(locked), 0);
    check({tag, "_line_len"},     32'(line_len), 0);
    check({tag, "_frame_lines"},  32'(frame_lines), 0);
    check({tag, "_frame_done"},   32'(frame_done), 0);
    check({tag, "_timing_err"},   32'(timing_err), 0);
    check({tag, "_err_count"},    32'(err_count), 0);
    check({tag, "_sample_rgb"},   32'(sample_rgb), 0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 0);
  endtask

  initial begin
    vif.hsync = 1'b1; vif.vsync = 1'b1; vif.blank_b = 1'b0;
    vif.r = 8'h00; vif.g = 8'h00; vif.b = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge vgaclk);
    @(negedge vgaclk);
    rst_n = 1'b1;

    // Nominal raster: partial frame, then the first full frame locks.
    frame(VT, -1, 0, 0, 0);
    check("locked_after_partial", 32'(locked), 0);
    frame(VT, -1, 0, 0, 0);
    check("locked_after_full", 32'(locked), 1);
    check("frame_lines_nominal", 32'(frame_lines), VT);
    frame(VT, -1, 0, 1, 0);
    check("sample_rgb_nominal", 32'(sample_rgb), 32'h05025A);
    check("sample_valid_nominal", 32'(sample_valid), 1);
    check("line_len_nominal", 32'(line_len), HT);
    check("err_count_nominal", 32'(err_count), 0);
    check("no_err_nominal", 32'(te_cnt), 0);

    // One short line while locked.
    te0 = te_cnt;
    frame(VT, 1, 0, 0, 0);
    check("short_te_pulses", 32'(te_cnt - te0), 1);
    check("short_err_count", 32'(err_count), 1);
    check("short_locked", 32'(locked), 0);
    check("short_sample_valid", 32'(sample_valid), 0);
    frame(VT, -1, 0, 0, 0);
    frame(VT, -1, 0, 0, 0);
    check("short_relocked", 32'(locked), 1);
    check("short_resampled", 32'(sample_valid), 1);
    check("short_single_err", 32'(te_cnt - te0), 1);

    // Frame one line short; caught at the vsync edge that closes it.
    te0 = te_cnt;
    frame(VT - 1, -1, 0, 0, 0);
    frame(VT, -1, 0, 1, 1);
    check("vshort_frame_lines", 32'(frame_lines), VT - 1);
    check("vshort_locked", 32'(locked), 0);
    check("vshort_err_count", 32'(err_count), 2);
    check("vshort_te_pulses", 32'(te_cnt - te0), 1);
    frame(VT, -1, 0, 0, 0);
    frame(VT, -1, 0, 0, 0);
    check("vshort_relocked", 32'(locked), 1);

    // Asynchronous reset mid-frame, then relock with coincident sync edges.
    frame(3, -1, 0, 0, 0);
    check("pre_reset_locked", 32'(locked), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge vgaclk);
    rst_n = 1'b1;
    te0 = te_cnt;
    frame(VT, -1, VS_SIM, 0, 0);
    check("sim_locked_partial", 32'(locked), 0);
    frame(VT, -1, VS_SIM, 0, 0);
    check("sim_locked_full", 32'(locked), 1);
    frame(VT, -1, VS_SIM, 1, 0);
    check("sim_still_locked", 32'(locked), 1);
    check("sim_frame_lines", 32'(frame_lines), VT);
    check("sim_sample_rgb", 32'(sample_rgb), 32'h05025A);
    check("sim_no_err", 32'(te_cnt - te0), 0);

    // Repeated short-line frames, each following a relock, saturate the counter.
    te0 = te_cnt;
    for (int i = 0; i < 260; i++) begin
      frame(VT, 1, VS_SIM, 0, 0);
      frame(VT, -1, VS_SIM, 0, 0);
      if (i == 9) check("sat_err_count_10", 32'(err_count), 10);
    end
    check("sat_err_count", 32'(err_count), 255);
    check("sat_te_pulses", 32'(te_cnt - te0), 260);
    check("sat_locked", 32'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
